// File: rtl/mlp_issue_ctrl.sv
// rtl/mlp_issue_ctrl.sv - batch issue controller with credit-gated result FIFO for the MLP pipeline
//
// Purpose: gates the fixed-latency pipeline's in_valid from a valid/ready input
// stream, captures every pipeline result into a small FIFO and only issues when
// the FIFO is guaranteed room for it (occ + inflight < FIFO_DEPTH). Counts a
// batch of batch_len_i vectors and pulses done_o when the last result is popped.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   start_i, batch_len_i    batch start (IDLE only) and batch length
//   busy_o, done_o, err_o   RUN/DRAIN flag, completion pulse, sticky capture error
//   s_valid_i, s_ready_o    upstream vector handshake
//   mdl_in_valid_o          pipeline in_valid (one issue per high cycle)
//   mdl_out_ready_i         pipeline result strobe
//   mdl_out_data_i          pipeline result, OUT_DIM elements of DATA_W bits
//   m_valid_o, m_ready_i    downstream result handshake
//   m_data_o, m_last_o      FIFO head and final-result-of-batch flag
module mlp_issue_ctrl #(
  parameter int DATA_W     = 16,
  parameter int OUT_DIM    = 4,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [CNT_W-1:0]          batch_len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  output logic                      mdl_in_valid_o,
  input  logic                      mdl_out_ready_i,
  input  logic [DATA_W*OUT_DIM-1:0] mdl_out_data_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [DATA_W*OUT_DIM-1:0] m_data_o,
  output logic                      m_last_o
);

  localparam int RES_W = DATA_W * OUT_DIM;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = OCC_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // The controller itself never needs LATENCY: credits make it latency-agnostic.
  if (LATENCY < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("mlp_issue_ctrl: LATENCY must be >=1 and FIFO_DEPTH a power of two >=2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   popped_q, popped_d;
  logic [OCC_W-1:0]   inflight_q, inflight_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [RES_W-1:0]   mem_q [FIFO_DEPTH];

  logic credit;
  logic issue;
  logic pop;
  logic bad_cap;
  logic push;
  logic retire;

  // Credit uses register values only, so a same-cycle pop frees credit next cycle.
  assign credit         = ({1'b0, occ_q} + {1'b0, inflight_q}) < DEPTH_SUM;
  assign s_ready_o      = (state_q == S_RUN) && credit;
  assign issue          = s_valid_i && s_ready_o;
  assign mdl_in_valid_o = issue;

  assign m_valid_o = (occ_q != '0);
  assign pop       = m_valid_o && m_ready_i;
  assign m_data_o  = m_valid_o ? mem_q[rd_ptr_q] : '0;
  assign m_last_o  = m_valid_o && (state_q == S_DRAIN) && (popped_q == (len_q - CNT_ONE));

  // A result nobody asked for, or one that would overflow the FIFO, is dropped.
  // Full with a simultaneous pop is a legal push: the head slot is freed this edge.
  assign bad_cap = mdl_out_ready_i && ((inflight_q == '0) || ((occ_q == DEPTH_OCC) && !pop));
  assign push    = mdl_out_ready_i && !bad_cap;
  assign retire  = mdl_out_ready_i && (inflight_q != '0);

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

  always_comb begin
    inflight_d = inflight_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (issue && !retire) begin
      inflight_d = inflight_q + OCC_W'(1);
    end else if (!issue && retire) begin
      inflight_d = inflight_q - OCC_W'(1);
    end
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issue ? (issued_q + CNT_ONE) : issued_q;
    popped_d = pop ? (popped_q + CNT_ONE) : popped_q;
    done_d   = 1'b0;
    err_d    = err_q | bad_cap;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (batch_len_i != '0) begin
            state_d  = S_RUN;
            len_d    = batch_len_i;
            issued_d = '0;
            popped_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue && ((issued_q + CNT_ONE) == len_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && ((popped_q + CNT_ONE) == len_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: occ_q gates visibility and m_data_o is forced to 0 when empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= mdl_out_data_i;
    end
  end

endmodule

// File: tb/tb_mlp_issue_ctrl.sv
// tb/tb_mlp_issue_ctrl.sv - self-checking bench for mlp_issue_ctrl with a delay-line pipeline model
module tb_mlp_issue_ctrl;

  localparam int DATA_W     = 16;
  localparam int OUT_DIM    = 4;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 16;
  localparam int RES_W      = DATA_W * OUT_DIM;

  localparam int IDLE_M  = 0;
  localparam int RUN_M   = 1;
  localparam int DRAIN_M = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] batch_len = '0;
  logic             busy, done, err;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             mdl_in_valid;
  logic             mdl_out_ready;
  logic [RES_W-1:0] mdl_out_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [RES_W-1:0] m_data;
  logic             m_last;
  logic             force_ordy = 1'b0;
  logic [CNT_W-1:0] dl_in = '0;

  always #5 clk = ~clk;

  mlp_issue_ctrl #(
    .DATA_W(DATA_W), .OUT_DIM(OUT_DIM), .LATENCY(LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .batch_len_i(batch_len),
    .busy_o(busy), .done_o(done), .err_o(err),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .mdl_in_valid_o(mdl_in_valid),
    .mdl_out_ready_i(mdl_out_ready), .mdl_out_data_i(mdl_out_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last)
  );

  function automatic logic [RES_W-1:0] pack(int idx);
    logic [RES_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_DIM; i++) r[i*DATA_W +: DATA_W] = DATA_W'(idx * 3 + i + 1);
    return r;
  endfunction

  // Fixed-latency pipeline stand-in: the result carries the issue index it was fed.
  logic [LATENCY-1:0] dl_v;
  logic [CNT_W-1:0]   dl_d [LATENCY];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_v <= '0;
      for (int i = 0; i < LATENCY; i++) dl_d[i] <= '0;
    end else begin
      dl_v    <= {dl_v[LATENCY-2:0], mdl_in_valid};
      dl_d[0] <= dl_in;
      for (int i = 1; i < LATENCY; i++) dl_d[i] <= dl_d[i-1];
    end
  end
  assign mdl_out_ready = dl_v[LATENCY-1] | force_ordy;
  assign mdl_out_data  = force_ordy ? pack(999) : pack(int'(dl_d[LATENCY-1]));

  // Reference model: batch bookkeeping plus a queue of (index, cycle it becomes visible).
  int checks = 0, failures = 0;
  int cyc = 0;
  int mstate = IDLE_M, m_len = 0, iss_cnt = 0, pop_cnt = 0;
  bit done_exp = 0, err_exp = 0;
  int q_idx[$];
  int q_av[$];
  int issues_seen = 0, pops_seen = 0, done_seen = 0;

  task automatic chk(string name, logic [RES_W-1:0] act, logic [RES_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mstate = IDLE_M; m_len = 0; iss_cnt = 0; pop_cnt = 0;
    done_exp = 0; err_exp = 0;
    q_idx.delete(); q_av.delete();
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit exp_sr, exp_mv, exp_ml, iss, pop, st, frc;
    int bl;
    dl_in = CNT_W'(iss_cnt);
    @(negedge clk);
    exp_sr = (mstate == RUN_M) && ((iss_cnt - pop_cnt) < FIFO_DEPTH);
    exp_mv = (q_av.size() > 0) && (q_av[0] <= cyc);
    exp_ml = exp_mv ? (q_idx[0] == m_len - 1) : 1'b0;
    chk("s_ready", RES_W'(s_ready), RES_W'(exp_sr));
    chk("mdl_in_valid", RES_W'(mdl_in_valid), RES_W'(s_valid && exp_sr));
    chk("m_valid", RES_W'(m_valid), RES_W'(exp_mv));
    if (exp_mv) chk("m_data", m_data, pack(q_idx[0]));
    chk("m_last", RES_W'(m_last), RES_W'(exp_ml));
    chk("busy", RES_W'(busy), RES_W'(mstate != IDLE_M));
    chk("done", RES_W'(done), RES_W'(done_exp));
    chk("err", RES_W'(err), RES_W'(err_exp));
    if (done) done_seen++;
    iss = s_valid && exp_sr;
    pop = exp_mv && m_ready;
    st  = start && (mstate == IDLE_M);
    frc = force_ordy;
    bl  = int'(batch_len);
    @(posedge clk);
    #1;
    done_exp = 0;
    if (iss) begin
      q_idx.push_back(iss_cnt);
      q_av.push_back(cyc + LATENCY + 1);
      iss_cnt++;
      issues_seen++;
      if (iss_cnt == m_len) mstate = DRAIN_M;
    end
    if (pop) begin
      void'(q_idx.pop_front());
      void'(q_av.pop_front());
      pop_cnt++;
      pops_seen++;
      if (pop_cnt == m_len) begin
        mstate = IDLE_M;
        done_exp = 1;
      end
    end
    if (st) begin
      if (bl == 0) done_exp = 1;
      else begin
        mstate = RUN_M; m_len = bl; iss_cnt = 0; pop_cnt = 0;
      end
    end
    if (frc) err_exp = 1;
    cyc++;
  endtask

  task automatic reset_midcycle();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy", RES_W'(busy), '0);
    chk("rst_done", RES_W'(done), '0);
    chk("rst_err", RES_W'(err), '0);
    chk("rst_s_ready", RES_W'(s_ready), '0);
    chk("rst_mdl_in_valid", RES_W'(mdl_in_valid), '0);
    chk("rst_m_valid", RES_W'(m_valid), '0);
    chk("rst_m_last", RES_W'(m_last), '0);
    chk("rst_m_data", m_data, '0);
    model_reset();
    start = 0; s_valid = 0; m_ready = 0; force_ordy = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_batch(int len, int sv_pct, int mr_pct, int spur_pct, int budget,
                           output int pops, output int dones);
    int p0, d0, n;
    p0 = pops_seen; d0 = done_seen; n = 0;
    start = 1; batch_len = CNT_W'(len); s_valid = 0; m_ready = 0;
    step();
    start = 0;
    while (mstate != IDLE_M && n < budget) begin
      s_valid   = ($urandom_range(99) < sv_pct);
      m_ready   = ($urandom_range(99) < mr_pct);
      start     = ($urandom_range(99) < spur_pct);
      batch_len = CNT_W'($urandom_range(60));
      step();
      n++;
    end
    chk("batch_timeout", RES_W'(mstate == IDLE_M), RES_W'(1));
    start = 0; s_valid = 0; m_ready = 0;
    step();
    pops = pops_seen - p0;
    dones = done_seen - d0;
  endtask

  typedef struct {
    int len;
    int sv_pct;
    int mr_pct;
    int spur_pct;
    int exp_pops;
    int exp_dones;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int pops, dones, i0, n;

    vecs[0] = '{len: 5,  sv_pct: 100, mr_pct: 100, spur_pct: 0,  exp_pops: 5,  exp_dones: 1};
    vecs[1] = '{len: 1,  sv_pct: 100, mr_pct: 100, spur_pct: 0,  exp_pops: 1,  exp_dones: 1};
    vecs[2] = '{len: 0,  sv_pct: 100, mr_pct: 100, spur_pct: 0,  exp_pops: 0,  exp_dones: 1};
    vecs[3] = '{len: 13, sv_pct: 70,  mr_pct: 50,  spur_pct: 0,  exp_pops: 13, exp_dones: 1};
    vecs[4] = '{len: 30, sv_pct: 100, mr_pct: 30,  spur_pct: 0,  exp_pops: 30, exp_dones: 1};
    vecs[5] = '{len: 9,  sv_pct: 40,  mr_pct: 100, spur_pct: 50, exp_pops: 9,  exp_dones: 1};
    vecs[6] = '{len: 24, sv_pct: 100, mr_pct: 100, spur_pct: 20, exp_pops: 24, exp_dones: 1};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Asynchronous reset mid-cycle, then quiet idle cycles.
    reset_midcycle();
    for (int k = 0; k < 10; k++) step();

    for (int v = 0; v < 7; v++) begin
      run_batch(vecs[v].len, vecs[v].sv_pct, vecs[v].mr_pct, vecs[v].spur_pct, 2000, pops, dones);
      chk($sformatf("vec%0d_pops", v), RES_W'(pops), RES_W'(vecs[v].exp_pops));
      chk($sformatf("vec%0d_dones", v), RES_W'(dones), RES_W'(vecs[v].exp_dones));
    end

    // Backpressure: m_ready low caps issues at FIFO_DEPTH; one pop buys exactly one more.
    i0 = issues_seen;
    start = 1; batch_len = CNT_W'(20); s_valid = 1; m_ready = 0;
    step();
    start = 0;
    for (int k = 0; k < 30; k++) step();
    chk("bp_issues_capped", RES_W'(issues_seen - i0), RES_W'(FIFO_DEPTH));
    chk("bp_s_ready_low", RES_W'(s_ready), '0);
    m_ready = 1;
    step();
    m_ready = 0;
    for (int k = 0; k < 10; k++) step();
    chk("bp_one_more_issue", RES_W'(issues_seen - i0), RES_W'(FIFO_DEPTH + 1));
    m_ready = 1;
    n = 0;
    while (mstate != IDLE_M && n < 500) begin step(); n++; end
    step();
    chk("bp_all_issued", RES_W'(issues_seen - i0), RES_W'(20));
    chk("bp_err_clear", RES_W'(err), '0);
    m_ready = 0; s_valid = 0;

    // Unsolicited result in IDLE: sticky error, nothing enters the FIFO.
    force_ordy = 1;
    step();
    force_ordy = 0;
    for (int k = 0; k < 5; k++) step();
    chk("perr_sticky", RES_W'(err), RES_W'(1));
    chk("perr_fifo_empty", RES_W'(m_valid), '0);
    reset_midcycle();
    chk("perr_cleared_by_reset", RES_W'(err), '0);

    // Reset after 3 issues of a 6-vector batch, then a clean 2-vector batch.
    start = 1; batch_len = CNT_W'(6); s_valid = 1; m_ready = 0;
    step();
    start = 0;
    n = 0;
    while (iss_cnt < 3 && n < 50) begin step(); n++; end
    chk("midrst_three_issued", RES_W'(iss_cnt), RES_W'(3));
    s_valid = 0;
    reset_midcycle();
    run_batch(2, 100, 100, 0, 200, pops, dones);
    chk("midrst_pops", RES_W'(pops), RES_W'(2));
    chk("midrst_err", RES_W'(err), '0);

    // Randomized batches against the reference model.
    for (int r = 0; r < 10; r++) begin
      int len;
      len = $urandom_range(1, 40);
      run_batch(len, $urandom_range(30, 100), $urandom_range(20, 100), 10, 3000, pops, dones);
      chk($sformatf("rand%0d_pops", r), RES_W'(pops), RES_W'(len));
      chk($sformatf("rand%0d_dones", r), RES_W'(dones), RES_W'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
